// File: rtl/seq_sub_pkg.sv
// rtl/seq_sub_pkg.sv - shared types and constants for the sequential 64-bit subtractor
package seq_sub_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_sub_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/seq_sub_64bit_if.sv
// rtl/seq_sub_64bit_if.sv - start/busy/done operand and result bundle for seq_sub_64bit
interface seq_sub_64bit_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             negative;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, negative, zero, carry, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, negative, zero, carry, overflow
    );
endinterface

// File: rtl/cla_16bit.sv
// rtl/cla_16bit.sv - 16-bit two-level carry-lookahead adder with group generate/propagate outputs
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        gg,
    output logic        pg
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        gg    = 1'b0;
        pg    = 1'b0;

        for (int k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end

        // Second lookahead level: every group carry-in straight from cin.
        grp_c[0] = cin;
        grp_c[1] = grp_g[0] | (grp_p[0] & cin);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & cin);

        gg = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
           | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
        pg = &grp_p;

        for (int k = 0; k < 4; k++) begin
            c[4*k] = grp_c[k];
            for (int j = 1; j < 4; j++) begin
                c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
            end
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/seq_sub_64bit.sv
// rtl/seq_sub_64bit.sv - slice-serial a - b through one cla_16bit; N/Z/C/V flags under SEQ_SUB_FLAGS_EN
module seq_sub_64bit
    import seq_sub_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NSLICE = WIDTH / SLICE_W
) (
    input  logic           clk,
    input  logic           reset,
    seq_sub_64bit_if.slave bus
);
    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    seq_sub_state_t state_q;
    seq_sub_state_t state_d;
    logic           accept;
    logic           busy;
    logic           done;

    logic [NSLICE-1:0][SLICE_W-1:0] a_q;
    logic [NSLICE-1:0][SLICE_W-1:0] nb_q;
    logic [NSLICE-1:0][SLICE_W-1:0] diff_q;
    logic [IDX_W-1:0]               idx_q;
    logic                           carry_q;

    logic [SLICE_W-1:0] sum;
    logic               gg;
    logic               pg;
    logic               carry_nx;
    logic               last_slice;
    flags_t             flags_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE accepts a new start just like IDLE so back-to-back ops have no bubble.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    cla_16bit u_cla (
        .a   (a_q[idx_q]),
        .b   (nb_q[idx_q]),
        .cin (carry_q),
        .sum (sum),
        .gg  (gg),
        .pg  (pg)
    );

    assign carry_nx   = gg | (pg & carry_q);
    assign last_slice = (state_q == RUN) && (idx_q == LAST_IDX);

    // Subtraction as a + ~b + 1: invert b at capture, seed the carry with 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            nb_q    <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            nb_q    <= ~bus.b;
            idx_q   <= '0;
            carry_q <= 1'b1;
        end else if (state_q == RUN) begin
            diff_q[idx_q] <= sum;
            carry_q       <= carry_nx;
            idx_q         <= idx_q + 1'b1;
        end
    end

`ifdef SEQ_SUB_FLAGS_EN
    logic zero_acc_q;
    logic sum_zero;
    logic a_msb;
    logic b_msb;

    assign sum_zero = (sum == '0);
    assign a_msb    = a_q[NSLICE-1][SLICE_W-1];
    assign b_msb    = ~nb_q[NSLICE-1][SLICE_W-1];

    // Flags latch on the final slice edge so they are valid alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_acc_q <= 1'b0;
            flags_q    <= '0;
        end else if (accept) begin
            zero_acc_q <= 1'b1;
        end else if (state_q == RUN) begin
            zero_acc_q <= zero_acc_q & sum_zero;
            if (last_slice) begin
                flags_q.n <= sum[SLICE_W-1];
                flags_q.z <= zero_acc_q & sum_zero;
                flags_q.c <= carry_nx;
                flags_q.v <= (a_msb != b_msb) & (sum[SLICE_W-1] != a_msb);
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = last_slice;
    assign flags_q     = '0;
`endif

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.diff     = diff_q;
    assign bus.negative = flags_q.n;
    assign bus.zero     = flags_q.z;
    assign bus.carry    = flags_q.c;
    assign bus.overflow = flags_q.v;

endmodule

// File: tb/tb_seq_sub_64bit.sv
// tb/tb_seq_sub_64bit.sv - randomized self-checking bench for seq_sub_64bit against an arithmetic model
module tb_seq_sub_64bit;
    localparam int WIDTH = 64;
    localparam int LAT   = 4;
`ifdef SEQ_SUB_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_sub_64bit_if #(.WIDTH(WIDTH)) bus_if ();

    seq_sub_64bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [3:0] ref_flags(input logic [63:0] a, input logic [63:0] b);
        logic [63:0]        d;
        logic signed [64:0] r;
        d = a - b;
        r = $signed({a[63], a}) - $signed({b[63], b});
        if (!FLAGS_EN) return 4'b0000;
        return {d[63], d == 64'd0, a >= b, r[64] != r[63]};
    endfunction

    function automatic logic [3:0] got_flags();
        return {bus_if.negative, bus_if.zero, bus_if.carry, bus_if.overflow};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus_if.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, output int lat,
                          output logic busy1, output logic [63:0] d, output logic [3:0] f,
                          output logic done_after);
        @(negedge clk);
        bus_if.a = a; bus_if.b = b; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        busy1 = bus_if.busy;
        wait_done(lat);
        d = bus_if.diff;
        f = got_flags();
        @(posedge clk); #1;
        done_after = bus_if.done;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        n_checks++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus_if.done); end
        n_checks++; if (bus_if.diff !== 64'd0) begin n_fail++; $display("FAIL reset_diff got=%h exp=0", bus_if.diff); end
        n_checks++; if (got_flags() !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", got_flags()); end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [63:0] va [6];
        logic [63:0] vb [6];
        int lat; logic busy1, done_after; logic [63:0] d; logic [3:0] f;
        va[0] = 64'd100;                 vb[0] = 64'd100;
        va[1] = 64'd0;                   vb[1] = 64'd1;
        va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'd1;
        va[3] = 64'h0000_0000_0001_0000; vb[3] = 64'd1;
        va[4] = 64'h0001_0000_0000_0000; vb[4] = 64'd1;
        va[5] = 64'h7FFF_FFFF_FFFF_FFFF; vb[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], lat, busy1, d, f, done_after);
            n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy got=%b exp=1", i, busy1); end
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            n_checks++; if (d !== va[i] - vb[i]) begin n_fail++; $display("FAIL dir%0d_diff got=%h exp=%h", i, d, va[i] - vb[i]); end
            n_checks++; if (f !== ref_flags(va[i], vb[i])) begin n_fail++; $display("FAIL dir%0d_flags got=%b exp=%b", i, f, ref_flags(va[i], vb[i])); end
            n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done_after); end
        end
    endtask

    task automatic test_random();
        int lat; logic busy1, done_after; logic [63:0] a, b, d; logic [3:0] f;
        for (int i = 0; i < 25; i++) begin
            a = rnd64();
            b = (i % 5 == 0) ? a : rnd64();
            if (i % 7 == 3) b = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, b[47:0]};
            run_op(a, b, lat, busy1, d, f, done_after);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            n_checks++; if (d !== a - b) begin n_fail++; $display("FAIL rnd%0d_diff a=%h b=%h got=%h exp=%h", i, a, b, d, a - b); end
            n_checks++; if (f !== ref_flags(a, b)) begin n_fail++; $display("FAIL rnd%0d_flags got=%b exp=%b", i, f, ref_flags(a, b)); end
        end
    endtask

    task automatic test_start_ignored();
        logic [63:0] a1, b1; int lat;
        a1 = rnd64(); b1 = rnd64();
        @(negedge clk);
        bus_if.a = a1; bus_if.b = b1; bus_if.start = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus_if.a = rnd64(); bus_if.b = rnd64();
            @(posedge clk); #1;
            if (bus_if.done) begin lat = i; break; end
        end
        bus_if.start = 1'b0;
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL held_start_latency got=%0d exp=%0d", lat, LAT); end
        n_checks++; if (bus_if.diff !== a1 - b1) begin n_fail++; $display("FAIL held_start_diff got=%h exp=%h", bus_if.diff, a1 - b1); end
        n_checks++; if (got_flags() !== ref_flags(a1, b1)) begin n_fail++; $display("FAIL held_start_flags got=%b exp=%b", got_flags(), ref_flags(a1, b1)); end
        @(posedge clk); #1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL held_start_idle got=%b exp=0", bus_if.busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a1, b1, a2, b2; int lat;
        a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = a2 + 64'd1;
        @(negedge clk);
        bus_if.a = a1; bus_if.b = b1; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        wait_done(lat);
        n_checks++; if (bus_if.diff !== a1 - b1) begin n_fail++; $display("FAIL b2b_first_diff got=%h exp=%h", bus_if.diff, a1 - b1); end
        bus_if.a = a2; bus_if.b = b2; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", bus_if.busy); end
        n_checks++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_low got=%b exp=0", bus_if.done); end
        wait_done(lat);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
        n_checks++; if (bus_if.diff !== a2 - b2) begin n_fail++; $display("FAIL b2b_second_diff got=%h exp=%h", bus_if.diff, a2 - b2); end
        n_checks++; if (got_flags() !== ref_flags(a2, b2)) begin n_fail++; $display("FAIL b2b_second_flags got=%b exp=%b", got_flags(), ref_flags(a2, b2)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat; logic busy1, done_after, saw_done; logic [63:0] a, b, d; logic [3:0] f;
        @(negedge clk);
        bus_if.a = 64'h1234_5678_9ABC_DEF0; bus_if.b = 64'h0FED_CBA9_8765_4321; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus_if.busy); end
        n_checks++; if (bus_if.diff !== 64'd0) begin n_fail++; $display("FAIL abort_diff got=%h exp=0", bus_if.diff); end
        n_checks++; if (got_flags() !== 4'b0000) begin n_fail++; $display("FAIL abort_flags got=%b exp=0000", got_flags()); end
        saw_done = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (bus_if.done) saw_done = 1'b1; end
        @(negedge clk) reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (bus_if.done) saw_done = 1'b1; end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
        a = rnd64(); b = rnd64();
        run_op(a, b, lat, busy1, d, f, done_after);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL post_abort_latency got=%0d exp=%0d", lat, LAT); end
        n_checks++; if (d !== a - b) begin n_fail++; $display("FAIL post_abort_diff got=%h exp=%h", d, a - b); end
        n_checks++; if (f !== ref_flags(a, b)) begin n_fail++; $display("FAIL post_abort_flags got=%b exp=%b", f, ref_flags(a, b)); end
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
